// File: rtl/mmio_uart_tx.sv
// Buffered UART transmitter fed by an MMIO command word with a toggle push handshake.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module mmio_uart_tx #(
    parameter int unsigned CLOCKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cmdWord,
    output logic [31:0] statusWord,
    output logic        txd
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q, wr_next, rd_next;
    logic        full_q, empty_q, ack_q;
    logic        push, pop, bit_end;
    logic [7:0]  rd_data;

    assign push    = (cmdWord[31] != ack_q) && !full_q;
    assign wr_next = wr_q + (AW + 1)'(push);
    assign rd_next = rd_q + (AW + 1)'(pop);
    assign rd_data = mem[rd_q[AW-1:0]];
    assign bit_end = (cnt_q == 16'(CLOCKS_PER_BIT - 1));

    always_ff @(posedge clock) begin
        if (push) mem[wr_q[AW-1:0]] <= cmdWord[7:0];
    end

    // full/empty are registered from the next pointers, so a same-edge pop never frees room early.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            wr_q    <= wr_next;
            rd_q    <= rd_next;
            full_q  <= (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
            empty_q <= (wr_next == rd_next);
            if (push) ack_q <= cmdWord[31];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    par_d   = ^rd_data;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d = '0;
                    // Pop straight from STOP so queued frames run back-to-back without an idle cycle.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        par_d   = ^rd_data;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    logic parity_present;
`ifdef MMIO_UART_TX_PARITY_EN
    assign parity_present = 1'b1;
`else
    assign parity_present = 1'b0;
`endif

    assign txd        = txd_q;
    assign statusWord = {ack_q, 27'd0, parity_present, (state_q != IDLE), empty_q, full_q};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: pushed bytes are queued and matched against frames decoded from txd.
module tb_mmio_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PAR = 32'h8;
`else
    localparam int NB = 10;
    localparam logic [31:0] PAR = 32'h0;
`endif
    localparam int FRAME = NB * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cmdWord = '0;
    logic [31:0] statusWord;
    logic        txd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] sb[$];
    int starts[$];

    mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .cmdWord(cmdWord), .statusWord(statusWord), .txd(txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame decoder: samples each bit at its middle clock, abandons a frame on reset.
    initial begin : monitor
        logic prev;
        logic bits [NB];
        logic aborted;
        int   t0;
        logic [7:0] data;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev = 1'b1;
            end else if (prev && !txd) begin
                t0 = cyc;
                aborted = 1'b0;
                for (int off = 1; off < FRAME; off++) begin
                    @(negedge clock);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (off % CPB == 2) bits[off / CPB] = txd;
                end
                prev = 1'b1;
                if (!aborted) begin
                    starts.push_back(t0);
                    for (int i = 0; i < 8; i++) data[i] = bits[i+1];
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[NB-1]), 32'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_frame", {24'd0, data}, 32'hFFFFFFFF);
                    end else begin
                        logic [7:0] exp;
                        exp = sb.pop_front();
                        check("frame_data", {24'd0, data}, {24'd0, exp});
`ifdef MMIO_UART_TX_PARITY_EN
                        check("parity_bit", 32'(bits[9]), 32'(^exp));
`endif
                    end
                end
            end else begin
                prev = txd;
            end
        end
    end

    task automatic push_byte(input logic tgl, input logic [7:0] b, input bit expect_frame);
        cmdWord = {tgl, 23'd0, b};
        if (expect_frame) sb.push_back(b);
    endtask

    task automatic wait_ack(input logic tgl, output int t);
        bit seen;
        seen = 1'b0;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (statusWord[31] == tgl) begin
                seen = 1'b1;
                t = cyc;
                break;
            end
        end
        if (!seen) check("ack_timeout", 32'(statusWord[31]), 32'(tgl));
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            if (statusWord[1] && !statusWord[2]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("idle_timeout", statusWord, 32'h2 | PAR);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int t1, t6, tn, n, base, highs;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_status", statusWord, 32'h2 | PAR);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Single byte 0x55
        push_byte(1'b1, 8'h55, 1'b1);
        @(negedge clock);
        check("single_ack", statusWord, 32'h80000000 | PAR);
        @(negedge clock);
        check("single_busy", statusWord, 32'h80000006 | PAR);
        check("single_start_txd", 32'(txd), 32'd0);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!statusWord[2]) break;
            n++;
        end
        check("single_busy_len", 32'(n), 32'(FRAME));
        repeat (3) @(negedge clock);

        // Fill the FIFO, then one more push that must wait for room
        base = starts.size();
        push_byte(1'b0, 8'h01, 1'b1); wait_ack(1'b0, t1);
        push_byte(1'b1, 8'h02, 1'b1); wait_ack(1'b1, tn);
        push_byte(1'b0, 8'h03, 1'b1); wait_ack(1'b0, tn);
        push_byte(1'b1, 8'h04, 1'b1); wait_ack(1'b1, tn);
        push_byte(1'b0, 8'h05, 1'b1); wait_ack(1'b0, tn);
        check("fill_full", 32'(statusWord[0]), 32'd1);
        push_byte(1'b1, 8'h06, 1'b1); wait_ack(1'b1, t6);
        check("full_push_delay", 32'(t6 - t1), 32'(FRAME + 2));
        wait_idle();
        check("fill_frames", 32'(starts.size() - base), 32'd6);
        for (int i = base + 1; i < starts.size(); i++)
            check("fill_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));

        // Same toggle rewrite: nothing enqueued
        base = starts.size();
        cmdWord = 32'h800000AA;
        repeat (10) @(negedge clock);
        check("same_toggle_status", statusWord, 32'h80000002 | PAR);
        check("same_toggle_frames", 32'(starts.size() - base), 32'd0);

        // Reset during DATA bit3 of 0xF0
        base = starts.size();
        push_byte(1'b0, 8'hF0, 1'b0); wait_ack(1'b0, tn);
        repeat (18) @(negedge clock);
        check("pre_reset_txd", 32'(txd), 32'd0);
        reset = 1'b0;
        #1;
        check("midframe_reset_txd", 32'(txd), 32'd1);
        check("midframe_reset_status", statusWord, 32'h2 | PAR);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (txd) highs++;
        end
        check("post_reset_idle", 32'(highs), 32'd60);
        check("post_reset_frames", 32'(starts.size() - base), 32'd0);

        // Back-to-back 0x00, 0xFF
        base = starts.size();
        push_byte(1'b1, 8'h00, 1'b1); wait_ack(1'b1, tn);
        push_byte(1'b0, 8'hFF, 1'b1); wait_ack(1'b0, tn);
        wait_idle();
        check("b2b_frames", 32'(starts.size() - base), 32'd2);
        if (starts.size() - base == 2)
            check("b2b_gap", 32'(starts[base+1] - starts[base]), 32'(FRAME));

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
